// File: rtl/serial_detect_pkg.sv
// ---------------------------------------------------------------------------
// serial_detect_pkg
//
// Shared types and width helpers for the serial detect scheduler and its
// 1->0 sequence detector.
//   sched_state_e : scheduler control state (IDLE / SHIFT / REPORT)
//   det_state_e   : detector state (S0..S3); S1/S2/S3 all mean "last bit was 1"
//   count_width() : bits needed to hold a hit count of 0..w
//   id_width()    : bits needed to hold a channel index 0..n-1
// ---------------------------------------------------------------------------
package serial_detect_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } sched_state_e;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } det_state_e;

    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ones_zero_detector_fsm.sv
// ---------------------------------------------------------------------------
// ones_zero_detector_fsm
//
// Four-state Mealy detector: y=1 flags a 0 that follows one or more 1s.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous, active-low; forces S0
//   clear  : synchronous clear to S0 (wins over enable)
//   enable : advance the state on this edge
//   x      : serial input bit
//   y      : Mealy output, valid whenever enable is high
// ---------------------------------------------------------------------------
module ones_zero_detector_fsm
    import serial_detect_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic x,
    output logic y
);

    det_state_e state_q;
    det_state_e state_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        y       = 1'b0;

        if (clear) begin
            state_d = S0;
        end else if (enable) begin
            case (state_q)
                S0:      state_d = x ? S1 : S0;
                S1:      state_d = x ? S3 : S0;
                S3:      state_d = x ? S2 : S0;
                S2:      state_d = x ? S2 : S0;
                default: state_d = S0;
            endcase
        end

        // Every non-S0 state remembers a preceding 1, so a 0 now is a hit.
        if (state_q != S0) begin
            y = ~x;
        end
    end

endmodule

// File: rtl/serial_detect_scheduler.sv
// ---------------------------------------------------------------------------
// serial_detect_scheduler
//
// Round-robin scheduler sharing one 1->0 serial detector among N_CH word
// producers. A granted word is shifted LSB-first through the detector, one
// bit per clock, and the hit count is returned with the channel id.
// Ports:
//   clock      : rising-edge clock
//   reset      : asynchronous, active-low
//   req_valid  : per-channel word offered
//   req_data   : channel i word at [i*W +: W]
//   req_ready  : one-hot accept pulse (combinational, only in IDLE)
//   res_valid  : result available (held until res_ready)
//   res_ready  : consumer accepts result
//   res_ch     : channel that produced the result
//   res_count  : number of detector hits in the word
//   busy       : high while shifting or reporting
// ---------------------------------------------------------------------------
module serial_detect_scheduler
    import serial_detect_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_CH-1:0]               req_valid,
    input  logic [N_CH*W-1:0]             req_data,
    output logic [N_CH-1:0]               req_ready,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [id_width(N_CH)-1:0]     res_ch,
    output logic [count_width(W)-1:0]     res_count,
    output logic                          busy
);

    localparam int ID_W  = id_width(N_CH);
    localparam int CNT_W = count_width(W);

    sched_state_e     state_q,  state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  res_ch_q, res_ch_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [W-1:0]     shreg_q,  shreg_d;

    logic             grant_any;
    logic [ID_W-1:0]  grant_idx;
    logic [W-1:0]     grant_word;
    logic             det_clear;
    logic             det_en;
    logic             det_y;

    // Round-robin search: walk offsets from high to low so the smallest
    // offset from rr_ptr (the highest priority) is the last to be written.
    always_comb begin
        int c;
        grant_any = 1'b0;
        grant_idx = '0;
        c         = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            c = int'(rr_ptr_q) + k;
            if (c >= N_CH) begin
                c = c - N_CH;
            end
            if (req_valid[ID_W'(c)]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(c);
            end
        end
    end

    always_comb begin
        grant_word = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_idx == ID_W'(i)) begin
                grant_word = req_data[i*W +: W];
            end
        end
    end

    ones_zero_detector_fsm u_det (
        .clock  (clock),
        .reset  (reset),
        .clear  (det_clear),
        .enable (det_en),
        .x      (shreg_q[0]),
        .y      (det_y)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        res_ch_d  = res_ch_q;
        count_d   = count_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        req_ready = '0;
        det_clear = (state_q == IDLE);
        det_en    = (state_q == SHIFT);

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    req_ready[grant_idx] = 1'b1;
                    shreg_d  = grant_word;
                    count_d  = '0;
                    bitcnt_d = '0;
                    res_ch_d = grant_idx;
                    rr_ptr_d = (grant_idx == ID_W'(N_CH - 1)) ? '0
                                                              : grant_idx + ID_W'(1);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d  = shreg_q >> 1;
                count_d  = count_q + CNT_W'(det_y);
                bitcnt_d = bitcnt_q + CNT_W'(1);
                if (bitcnt_q == CNT_W'(W - 1)) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            res_ch_q <= '0;
            count_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            res_ch_q <= res_ch_d;
            count_q  <= count_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    // Word payload only; its contents are meaningless outside SHIFT.
    always_ff @(posedge clock) begin
        shreg_q <= shreg_d;
    end

    assign res_valid = (state_q == REPORT);
    assign busy      = (state_q != IDLE);
    assign res_ch    = res_ch_q;
    assign res_count = count_q;

endmodule

// File: tb/tb_serial_detect_scheduler.sv
module tb_serial_detect_scheduler;

    localparam int N_CH  = 4;
    localparam int W     = 8;
    localparam int ID_W  = $clog2(N_CH);
    localparam int CNT_W = $clog2(W + 1);

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic [N_CH-1:0]      req_valid = '0;
    logic [N_CH*W-1:0]    req_data = '0;
    logic [N_CH-1:0]      req_ready;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic [ID_W-1:0]      res_ch;
    logic [CNT_W-1:0]     res_count;
    logic                 busy;

    int errors = 0;
    int checks = 0;

    // Transaction-level model: phase 0 = waiting, 1 = word in flight, 2 = result held
    int m_phase = 0;
    int m_left  = 0;
    int m_rr    = 0;
    int m_ch    = 0;
    int m_cnt   = 0;

    serial_detect_scheduler #(.N_CH(N_CH), .W(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_ch    (res_ch),
        .res_count (res_count),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Hits = number of 1->0 transitions seen in LSB-first bit order.
    function automatic int hits(input logic [W-1:0] w);
        int n;
        n = 0;
        for (int i = 1; i < W; i++) begin
            if (w[i-1] && !w[i]) n++;
        end
        return n;
    endfunction

    // Per-cycle compare against the model, then advance the model with the
    // inputs that the coming rising edge will sample.
    always @(negedge clock) begin
        int g;
        logic [N_CH-1:0] exp_rr;
        if (!reset) begin
            m_phase = 0; m_rr = 0; m_ch = 0; m_cnt = 0; m_left = 0;
            chk("rst res_valid", int'(res_valid), 0);
            chk("rst busy", int'(busy), 0);
            chk("rst res_ch", int'(res_ch), 0);
            chk("rst res_count", int'(res_count), 0);
            if (req_valid == '0) chk("rst req_ready", int'(req_ready), 0);
        end else begin
            g = -1;
            if (m_phase == 0) begin
                for (int k = 0; k < N_CH; k++) begin
                    int c;
                    c = (m_rr + k) % N_CH;
                    if (req_valid[c] && g < 0) g = c;
                end
            end
            exp_rr = (g >= 0) ? (N_CH'(1) << g) : '0;
            chk("mdl req_ready", int'(req_ready), int'(exp_rr));
            chk("mdl res_valid", int'(res_valid), (m_phase == 2) ? 1 : 0);
            chk("mdl busy", int'(busy), (m_phase != 0) ? 1 : 0);
            chk("mdl res_ch", int'(res_ch), m_ch);
            if (m_phase == 2) chk("mdl res_count", int'(res_count), m_cnt);

            case (m_phase)
                0: if (g >= 0) begin
                    m_ch    = g;
                    m_rr    = (g + 1) % N_CH;
                    m_cnt   = hits(req_data[g*W +: W]);
                    m_left  = W;
                    m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (res_ready) m_phase = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 100) begin
            tick();
            k++;
        end
        chk({name, " idle"}, int'(busy), 0);
    endtask

    task automatic run_word(input logic [N_CH-1:0] mask, input int ch,
                            input logic [W-1:0] d, input int exp_cnt, input string name);
        bit seen;
        int k;
        req_data[ch*W +: W] = d;
        req_valid = mask;
        res_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (req_ready != '0) seen = 1;
        end
        chk({name, " grant"}, int'(req_ready), 1 << ch);
        tick();
        req_valid = '0;
        k = 0;
        seen = 0;
        while (!seen && k < 40) begin
            @(negedge clock);
            if (res_valid) seen = 1;
            else k++;
        end
        chk({name, " latency"}, k, W);
        chk({name, " count"}, int'(res_count), exp_cnt);
        chk({name, " ch"}, int'(res_ch), ch);
        tick();
    endtask

    initial begin
        int order[5];
        int ng;
        int k;
        bit seen;
        logic [ID_W-1:0]  hold_ch;
        logic [CNT_W-1:0] hold_cnt;

        // Reset state
        repeat (3) tick();
        chk("reset req_ready", int'(req_ready), 0);
        chk("reset res_valid", int'(res_valid), 0);
        chk("reset busy", int'(busy), 0);
        reset = 1'b1;
        tick();

        // Single words with hand-computed counts
        run_word(4'b0001, 0, 8'b0000_0110, 1, "ch0 06");
        run_word(4'b0100, 2, 8'h55, 4, "ch2 55");
        run_word(4'b0010, 1, 8'hFF, 0, "ch1 FF");
        run_word(4'b0001, 0, 8'h80, 0, "ch0 80");
        run_word(4'b1000, 3, 8'h80, 0, "carry 80");
        run_word(4'b1000, 3, 8'h00, 0, "carry 00");
        run_word(4'b0001, 0, 8'b1011_0110, 2, "ch0 B6");

        // All channels requesting from reset: rotation 0,1,2,3,0
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        req_data = {8'h0F, 8'h33, 8'hA5, 8'h01};
        req_valid = '1;
        res_ready = 1'b1;
        ng = 0;
        k = 0;
        while (ng < 5 && k < 200) begin
            @(negedge clock);
            if (req_ready != '0) begin
                chk("rr onehot", int'($onehot(req_ready)), 1);
                for (int i = 0; i < N_CH; i++) if (req_ready[i]) order[ng] = i;
                ng++;
                @(negedge clock);
                chk("rr pulse width", int'(req_ready), 0);
            end
            k++;
        end
        chk("rr grants seen", ng, 5);
        for (int i = 0; i < 5; i++) chk("rr order", order[i], i % N_CH);
        tick();
        req_valid = '0;
        wait_idle("rr");

        // Backpressure: result held 5 cycles with others requesting
        res_ready = 1'b0;
        req_data[1*W +: W] = 8'h06;
        req_valid = 4'b0010;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (req_ready[1]) seen = 1;
        end
        chk("bp grant", int'(seen), 1);
        tick();
        req_valid = '1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (res_valid) seen = 1;
        end
        chk("bp res_valid", int'(seen), 1);
        hold_ch = res_ch;
        hold_cnt = res_count;
        chk("bp count", int'(hold_cnt), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp hold valid", int'(res_valid), 1);
            chk("bp hold ch", int'(res_ch), 1);
            chk("bp hold count", int'(res_count), int'(hold_cnt));
            chk("bp no grant", int'(req_ready), 0);
        end
        tick();
        res_ready = 1'b1;
        @(negedge clock);
        chk("bp handshake no grant", int'(req_ready), 0);
        tick();
        @(negedge clock);
        chk("bp next grant", int'(req_ready), 4'b0100);
        tick();
        req_valid = '0;
        wait_idle("bp");

        // Reset during the fourth shifted bit
        req_data[2*W +: W] = 8'hFF;
        req_valid = 4'b0100;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (req_ready[2]) seen = 1;
        end
        chk("mid grant", int'(seen), 1);
        tick();
        req_valid = '0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("mid rst busy", int'(busy), 0);
        chk("mid rst res_valid", int'(res_valid), 0);
        chk("mid rst res_ch", int'(res_ch), 0);
        chk("mid rst res_count", int'(res_count), 0);
        chk("mid rst req_ready", int'(req_ready), 0);
        tick();
        reset = 1'b1;
        req_data[2*W +: W] = 8'h0F;
        run_word(4'b0101, 0, 8'h55, 4, "post rst");

        // Randomised traffic, checked by the model every cycle
        for (int cyc = 0; cyc < 1500; cyc++) begin
            req_valid = N_CH'($urandom_range(0, (1 << N_CH) - 1));
            req_data  = (N_CH*W)'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) reset = 1'b0;
            else reset = 1'b1;
            tick();
        end
        reset = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        tick();
        wait_idle("drain");
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
